// File: rtl/tlb_op_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : tlb_op_ctrl_if
// Description : Op-request / response bundle between the CP0/WB stage and the
//               TLB op controller. Also carries the Random counter value back
//               to CP0.
//               master : CP0 side (issues ops, accepts responses)
//               slave  : controller side (accepts ops, returns responses)
//               Port summary:
//                 op_valid/op_ready/op_code/op_cancel  request handshake
//                 op_index, op_vpn2/op_asid/op_g,
//                 op_pfn0/c0/d0/v0, op_pfn1/c1/d1/v1   CP0 operands
//                 res_valid/res_ready/res_op           response handshake
//                 res_miss/res_index                   TLBP result
//                 res_vpn2 .. res_v1                   TLBR data
//                 random                               current Random value
// Revision    : 1.0 - initial release
// ============================================================================
interface tlb_op_ctrl_if #(
  parameter int TLBNUM = 16
) ();
  localparam int IW = $clog2(TLBNUM);

  // Request
  logic          op_valid;
  logic          op_ready;
  logic [1:0]    op_code;
  logic          op_cancel;
  logic [IW-1:0] op_index;
  logic [18:0]   op_vpn2;
  logic [7:0]    op_asid;
  logic          op_g;
  logic [19:0]   op_pfn0;
  logic [2:0]    op_c0;
  logic          op_d0;
  logic          op_v0;
  logic [19:0]   op_pfn1;
  logic [2:0]    op_c1;
  logic          op_d1;
  logic          op_v1;

  // Response
  logic          res_valid;
  logic          res_ready;
  logic [1:0]    res_op;
  logic          res_miss;
  logic [IW-1:0] res_index;
  logic [18:0]   res_vpn2;
  logic [7:0]    res_asid;
  logic          res_g;
  logic [19:0]   res_pfn0;
  logic [2:0]    res_c0;
  logic          res_d0;
  logic          res_v0;
  logic [19:0]   res_pfn1;
  logic [2:0]    res_c1;
  logic          res_d1;
  logic          res_v1;

  logic [IW-1:0] random;

  modport master (
    output op_valid, op_code, op_cancel, op_index, op_vpn2, op_asid, op_g,
           op_pfn0, op_c0, op_d0, op_v0, op_pfn1, op_c1, op_d1, op_v1,
           res_ready,
    input  op_ready, res_valid, res_op, res_miss, res_index,
           res_vpn2, res_asid, res_g, res_pfn0, res_c0, res_d0, res_v0,
           res_pfn1, res_c1, res_d1, res_v1, random
  );

  modport slave (
    input  op_valid, op_code, op_cancel, op_index, op_vpn2, op_asid, op_g,
           op_pfn0, op_c0, op_d0, op_v0, op_pfn1, op_c1, op_d1, op_v1,
           res_ready,
    output op_ready, res_valid, res_op, res_miss, res_index,
           res_vpn2, res_asid, res_g, res_pfn0, res_c0, res_d0, res_v0,
           res_pfn1, res_c1, res_d1, res_v1, random
  );
endinterface
`default_nettype wire

// File: rtl/tlb_op_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tlb_op_ctrl
// Description : Sequences CP0 TLB instructions (TLBP, TLBR, TLBWI, TLBWR) onto
//               the TLB search port 1, read port and write port. One op at a
//               time: IDLE (accept) -> EXEC (drive TLB, 1 cycle) -> RESP
//               (hold registered result until taken). Owns the Random counter.
//               Port summary:
//                 clk, resetn        clock, async active-low reset
//                 op_if (slave)      op request / response / random
//                 s1_*               TLB search port 1 (odd_page tied 0)
//                 r_index, r_*       TLB read port
//                 we, w_index, w_*   TLB write port
// Revision    : 1.0 - initial release
// ============================================================================
module tlb_op_ctrl #(
  parameter  int TLBNUM = 16,
  localparam int IW     = $clog2(TLBNUM)
) (
  input  logic          clk,
  input  logic          resetn,
  tlb_op_ctrl_if.slave  op_if,
  // search port 1
  output logic [18:0]   s1_vpn2,
  output logic          s1_odd_page,
  output logic [7:0]    s1_asid,
  input  logic          s1_found,
  input  logic [IW-1:0] s1_index,
  // read port
  output logic [IW-1:0] r_index,
  input  logic [18:0]   r_vpn2,
  input  logic [7:0]    r_asid,
  input  logic          r_g,
  input  logic [19:0]   r_pfn0,
  input  logic [2:0]    r_c0,
  input  logic          r_d0,
  input  logic          r_v0,
  input  logic [19:0]   r_pfn1,
  input  logic [2:0]    r_c1,
  input  logic          r_d1,
  input  logic          r_v1,
  // write port
  output logic          we,
  output logic [IW-1:0] w_index,
  output logic [18:0]   w_vpn2,
  output logic [7:0]    w_asid,
  output logic          w_g,
  output logic [19:0]   w_pfn0,
  output logic [2:0]    w_c0,
  output logic          w_d0,
  output logic          w_v0,
  output logic [19:0]   w_pfn1,
  output logic [2:0]    w_c1,
  output logic          w_d1,
  output logic          w_v1
);

  localparam logic [1:0] OP_TLBP  = 2'b00;
  localparam logic [1:0] OP_TLBR  = 2'b01;
  localparam logic [1:0] OP_TLBWI = 2'b10;
  localparam logic [1:0] OP_TLBWR = 2'b11;

  localparam logic [IW-1:0] RANDOM_INIT = IW'(TLBNUM - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // One TLB entry worth of fields, in the same order everywhere it is packed.
  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } entry_t;

  state_t        state_q,     state_d;
  logic [1:0]    opc_q,       opc_d;
  entry_t        opnd_q,      opnd_d;
  logic [IW-1:0] r_index_q,   r_index_d;
  logic [IW-1:0] w_index_q,   w_index_d;
  logic [IW-1:0] random_q,    random_d;
  entry_t        res_q,       res_d;
  logic          res_miss_q,  res_miss_d;
  logic [IW-1:0] res_index_q, res_index_d;
  logic [1:0]    res_op_q,    res_op_d;

  entry_t op_ent;
  entry_t r_ent;

  assign op_ent = {op_if.op_vpn2, op_if.op_asid, op_if.op_g,
                   op_if.op_pfn0, op_if.op_c0, op_if.op_d0, op_if.op_v0,
                   op_if.op_pfn1, op_if.op_c1, op_if.op_d1, op_if.op_v1};

  assign r_ent  = {r_vpn2, r_asid, r_g,
                   r_pfn0, r_c0, r_d0, r_v0,
                   r_pfn1, r_c1, r_d1, r_v1};

  // --------------------------------------------------------------------------
  // State / operand / result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      opc_q       <= '0;
      opnd_q      <= '0;
      r_index_q   <= '0;
      w_index_q   <= '0;
      random_q    <= RANDOM_INIT;
      res_q       <= '0;
      res_miss_q  <= 1'b0;
      res_index_q <= '0;
      res_op_q    <= '0;
    end else begin
      state_q     <= state_d;
      opc_q       <= opc_d;
      opnd_q      <= opnd_d;
      r_index_q   <= r_index_d;
      w_index_q   <= w_index_d;
      random_q    <= random_d;
      res_q       <= res_d;
      res_miss_q  <= res_miss_d;
      res_index_q <= res_index_d;
      res_op_q    <= res_op_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    opc_d       = opc_q;
    opnd_d      = opnd_q;
    r_index_d   = r_index_q;
    w_index_d   = w_index_q;
    res_d       = res_q;
    res_miss_d  = res_miss_q;
    res_index_d = res_index_q;
    res_op_d    = res_op_q;
    // TLBNUM is a power of two, so the natural wrap takes 0 to TLBNUM-1.
    random_d    = random_q - 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (op_if.op_valid && !op_if.op_cancel) begin
          opc_d     = op_if.op_code;
          opnd_d    = op_ent;
          r_index_d = op_if.op_index;
          // TLBWR targets the Random value seen in the accept cycle,
          // i.e. before this cycle's decrement lands.
          w_index_d = (op_if.op_code == OP_TLBWR) ? random_q : op_if.op_index;
          state_d   = ST_EXEC;
        end
      end

      ST_EXEC: begin
        if (op_if.op_cancel) begin
          state_d = ST_IDLE;
        end else begin
          res_op_d = opc_q;
          case (opc_q)
            OP_TLBP: begin
              res_miss_d  = !s1_found;
              res_index_d = s1_found ? s1_index : '0;
            end
            OP_TLBR: begin
              res_d = r_ent;
            end
            default: begin
              // writes only report their op code
            end
          endcase
          state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        // Cancel drops the response even if it is being accepted.
        if (op_if.op_cancel || op_if.res_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign op_if.op_ready  = (state_q == ST_IDLE);
  assign op_if.res_valid = (state_q == ST_RESP);
  assign op_if.res_op    = res_op_q;
  assign op_if.res_miss  = res_miss_q;
  assign op_if.res_index = res_index_q;
  assign op_if.random    = random_q;

  assign {op_if.res_vpn2, op_if.res_asid, op_if.res_g,
          op_if.res_pfn0, op_if.res_c0, op_if.res_d0, op_if.res_v0,
          op_if.res_pfn1, op_if.res_c1, op_if.res_d1, op_if.res_v1} = res_q;

  assign s1_vpn2     = opnd_q.vpn2;
  assign s1_asid     = opnd_q.asid;
  assign s1_odd_page = 1'b0;
  assign r_index     = r_index_q;
  assign w_index     = w_index_q;

  assign {w_vpn2, w_asid, w_g,
          w_pfn0, w_c0, w_d0, w_v0,
          w_pfn1, w_c1, w_d1, w_v1} = opnd_q;

  // Decoded from registered state so an async reset drops it immediately;
  // cancel in the same cycle suppresses the write.
  assign we = (state_q == ST_EXEC) && (opc_q == OP_TLBWI || opc_q == OP_TLBWR)
              && !op_if.op_cancel;

endmodule
`default_nettype wire

// File: tb/tb_tlb_op_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_tlb_op_ctrl
// Description : Self-checking bench for tlb_op_ctrl. The bench plays the TLB
//               (entry array with search/read/write ports), keeps a reference
//               model of op sequencing, results and Random, compares on every
//               falling edge, and runs directed TLB op sequences with literal
//               expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tlb_op_ctrl;

  localparam int TLBNUM = 16;
  localparam int IW     = $clog2(TLBNUM);

  localparam logic [1:0] TLBP  = 2'b00;
  localparam logic [1:0] TLBR  = 2'b01;
  localparam logic [1:0] TLBWI = 2'b10;
  localparam logic [1:0] TLBWR = 2'b11;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } entry_t;

  logic clk;
  logic resetn;

  tlb_op_ctrl_if #(.TLBNUM(TLBNUM)) bus ();

  logic [18:0]   s1_vpn2;
  logic          s1_odd_page;
  logic [7:0]    s1_asid;
  logic          s1_found;
  logic [IW-1:0] s1_index;
  logic [IW-1:0] r_index;
  logic [18:0]   r_vpn2;
  logic [7:0]    r_asid;
  logic          r_g;
  logic [19:0]   r_pfn0;
  logic [2:0]    r_c0;
  logic          r_d0;
  logic          r_v0;
  logic [19:0]   r_pfn1;
  logic [2:0]    r_c1;
  logic          r_d1;
  logic          r_v1;
  logic          we;
  logic [IW-1:0] w_index;
  logic [18:0]   w_vpn2;
  logic [7:0]    w_asid;
  logic          w_g;
  logic [19:0]   w_pfn0;
  logic [2:0]    w_c0;
  logic          w_d0;
  logic          w_v0;
  logic [19:0]   w_pfn1;
  logic [2:0]    w_c1;
  logic          w_d1;
  logic          w_v1;

  tlb_op_ctrl #(.TLBNUM(TLBNUM)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .op_if       (bus),
    .s1_vpn2     (s1_vpn2),
    .s1_odd_page (s1_odd_page),
    .s1_asid     (s1_asid),
    .s1_found    (s1_found),
    .s1_index    (s1_index),
    .r_index     (r_index),
    .r_vpn2      (r_vpn2),
    .r_asid      (r_asid),
    .r_g         (r_g),
    .r_pfn0      (r_pfn0),
    .r_c0        (r_c0),
    .r_d0        (r_d0),
    .r_v0        (r_v0),
    .r_pfn1      (r_pfn1),
    .r_c1        (r_c1),
    .r_d1        (r_d1),
    .r_v1        (r_v1),
    .we          (we),
    .w_index     (w_index),
    .w_vpn2      (w_vpn2),
    .w_asid      (w_asid),
    .w_g         (w_g),
    .w_pfn0      (w_pfn0),
    .w_c0        (w_c0),
    .w_d0        (w_d0),
    .w_v0        (w_v0),
    .w_pfn1      (w_pfn1),
    .w_c1        (w_c1),
    .w_d1        (w_d1),
    .w_v1        (w_v1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic entry_t init_entry(input int i);
    entry_t e;
    e      = '0;
    e.vpn2 = 19'h40000 | 19'(i);
    e.asid = 8'hFF;
    e.pfn0 = 20'(i);
    return e;
  endfunction

  // --------------------------------------------------------------------------
  // TLB stand-in: search, read and write ports over an entry array
  // --------------------------------------------------------------------------
  entry_t tlb_mem [TLBNUM];
  entry_t w_ent;
  int     we_cnt = 0;

  assign w_ent = {w_vpn2, w_asid, w_g, w_pfn0, w_c0, w_d0, w_v0,
                  w_pfn1, w_c1, w_d1, w_v1};
  assign {r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0,
          r_pfn1, r_c1, r_d1, r_v1} = tlb_mem[r_index];

  always_comb begin
    s1_found = 1'b0;
    s1_index = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (tlb_mem[i].vpn2 == s1_vpn2 && (tlb_mem[i].g || tlb_mem[i].asid == s1_asid)) begin
        s1_found = 1'b1;
        s1_index = i[IW-1:0];
      end
    end
  end

  initial begin
    for (int i = 0; i < TLBNUM; i++) tlb_mem[i] = init_entry(i);
    forever begin
      @(posedge clk);
      if (we) begin
        tlb_mem[w_index] <= w_ent;
        we_cnt++;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Reference model. An accepted op is pending; one cycle later it executes
  // against the reference entry array; from then on its response is offered
  // until taken. Random is a closed-form function of cycles since reset.
  // --------------------------------------------------------------------------
  entry_t        ref_mem [TLBNUM];
  int            cyc = 0;
  logic          m_pend = 1'b0;
  int            m_since = 0;
  logic [1:0]    m_code = '0;
  entry_t        m_ent = '0;
  logic [IW-1:0] m_index = '0;
  logic [IW-1:0] m_widx = '0;
  entry_t        m_res = '0;
  logic          m_res_miss = 1'b0;
  logic [IW-1:0] m_res_index = '0;
  logic [1:0]    m_res_op = '0;

  function automatic int rand_at(input int c);
    return (TLBNUM - 1) - (c % TLBNUM);
  endfunction

  initial begin
    for (int i = 0; i < TLBNUM; i++) ref_mem[i] = init_entry(i);
    forever begin
      @(posedge clk);
      if (!resetn) begin
        m_pend      = 1'b0;
        m_since     = 0;
        m_res       = '0;
        m_res_miss  = 1'b0;
        m_res_index = '0;
        m_res_op    = '0;
        cyc         = 0;
      end else begin
        if (m_pend) begin
          if (bus.op_cancel) begin
            m_pend = 1'b0;
          end else if (m_since == 1) begin
            m_res_op = m_code;
            if (m_code == TLBP) begin
              int hit;
              hit = -1;
              for (int i = 0; i < TLBNUM; i++)
                if (hit < 0 && ref_mem[i].vpn2 == m_ent.vpn2 &&
                    (ref_mem[i].g || ref_mem[i].asid == m_ent.asid))
                  hit = i;
              m_res_miss  = (hit < 0);
              m_res_index = (hit < 0) ? '0 : IW'(hit);
            end else if (m_code == TLBR) begin
              m_res = ref_mem[m_index];
            end else begin
              ref_mem[(m_code == TLBWI) ? m_index : m_widx] = m_ent;
            end
            m_since = 2;
          end else if (bus.res_ready) begin
            m_pend = 1'b0;
          end
        end else if (bus.op_valid && !bus.op_cancel) begin
          m_pend  = 1'b1;
          m_since = 1;
          m_code  = bus.op_code;
          m_index = bus.op_index;
          m_widx  = IW'(rand_at(cyc));
          m_ent   = {bus.op_vpn2, bus.op_asid, bus.op_g, bus.op_pfn0, bus.op_c0,
                     bus.op_d0, bus.op_v0, bus.op_pfn1, bus.op_c1, bus.op_d1, bus.op_v1};
        end
        cyc++;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Per-cycle comparison against the model
  // --------------------------------------------------------------------------
  entry_t res_ent;
  assign res_ent = {bus.res_vpn2, bus.res_asid, bus.res_g, bus.res_pfn0, bus.res_c0,
                    bus.res_d0, bus.res_v0, bus.res_pfn1, bus.res_c1, bus.res_d1, bus.res_v1};

  always @(negedge clk) begin
    if (!resetn) begin
      chk("m_rst_op_ready", bus.op_ready, 1);
      chk("m_rst_res_valid", bus.res_valid, 0);
      chk("m_rst_we", we, 0);
      chk("m_rst_random", bus.random, TLBNUM - 1);
    end else begin
      logic exp_rv, exp_we;
      exp_rv = m_pend && m_since == 2;
      exp_we = m_pend && m_since == 1 && m_code[1] && !bus.op_cancel;
      chk("m_op_ready", bus.op_ready, !m_pend);
      chk("m_res_valid", bus.res_valid, exp_rv);
      chk("m_we", we, exp_we);
      chk("m_random", bus.random, rand_at(cyc));
      if (exp_rv) begin
        chk("m_res_op", bus.res_op, m_res_op);
        chk("m_res_miss", bus.res_miss, m_res_miss);
        chk("m_res_index", bus.res_index, m_res_index);
        chk("m_res_data", res_ent, m_res);
      end
      if (exp_we) begin
        chk("m_w_index", w_index, (m_code == TLBWI) ? m_index : m_widx);
        chk("m_w_data", w_ent, m_ent);
      end
      if (m_pend && m_since == 1 && m_code == TLBP) begin
        chk("m_s1_vpn2", s1_vpn2, m_ent.vpn2);
        chk("m_s1_asid", s1_asid, m_ent.asid);
        chk("m_s1_odd", s1_odd_page, 0);
      end
      if (m_pend && m_since == 1 && m_code == TLBR)
        chk("m_r_index", r_index, m_index);
    end
  end

  // --------------------------------------------------------------------------
  // Directed stimulus (driven 1 time unit after each rising edge)
  // --------------------------------------------------------------------------
  // Presents an op for one cycle; returns 1 unit into the EXEC cycle.
  task automatic issue(input logic [1:0] code, input logic [IW-1:0] idx, input entry_t e);
    bus.op_code  = code;
    bus.op_index = idx;
    {bus.op_vpn2, bus.op_asid, bus.op_g, bus.op_pfn0, bus.op_c0, bus.op_d0, bus.op_v0,
     bus.op_pfn1, bus.op_c1, bus.op_d1, bus.op_v1} = e;
    bus.op_valid = 1'b1;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    entry_t e;
    int     we_base;

    resetn        = 1'b1;
    bus.op_valid  = 1'b0;
    bus.op_cancel = 1'b0;
    bus.res_ready = 1'b1;
    issue_clear: begin
      bus.op_code = '0; bus.op_index = '0; bus.op_vpn2 = '0; bus.op_asid = '0;
      bus.op_g = 0; bus.op_pfn0 = '0; bus.op_c0 = '0; bus.op_d0 = 0; bus.op_v0 = 0;
      bus.op_pfn1 = '0; bus.op_c1 = '0; bus.op_d1 = 0; bus.op_v1 = 0;
    end
    #2 resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    // Reset state and Random wrap
    chk("rst_random", bus.random, 15);
    chk("rst_op_ready", bus.op_ready, 1);
    chk("rst_res_valid", bus.res_valid, 0);
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 1)  chk("rand_first_dec", bus.random, 14);
      if (k == 15) chk("rand_zero", bus.random, 0);
      if (k == 16) chk("rand_wrap", bus.random, 15);
    end

    // TLBWI idx 3
    e = '0; e.vpn2 = 19'h12345; e.asid = 8'h05; e.pfn0 = 20'hAB; e.v0 = 1'b1;
    we_base = we_cnt;
    issue(TLBWI, 4'd3, e);
    chk("wi_we", we, 1);
    chk("wi_w_index", w_index, 3);
    chk("wi_rv_exec", bus.res_valid, 0);
    step();
    chk("wi_rv_resp", bus.res_valid, 1);
    chk("wi_res_op", bus.res_op, 2);
    step();
    chk("wi_we_pulses", we_cnt - we_base, 1);
    chk("wi_idle", bus.op_ready, 1);

    // TLBP hit on index 3
    issue(TLBP, 4'd0, e);
    chk("p_s1_vpn2", s1_vpn2, 19'h12345);
    step();
    chk("p_rv", bus.res_valid, 1);
    chk("p_miss", bus.res_miss, 0);
    chk("p_index", bus.res_index, 3);
    step();

    // TLBP miss
    e = '0; e.vpn2 = 19'h7FFFF; e.asid = 8'h05;
    issue(TLBP, 4'd0, e);
    step();
    chk("pm_miss", bus.res_miss, 1);
    chk("pm_index", bus.res_index, 0);
    step();

    // Global entry at index 7 matches any ASID
    e = '0; e.vpn2 = 19'h22222; e.asid = 8'h09; e.g = 1'b1;
    e.pfn1 = 20'h55; e.c1 = 3'd3; e.d1 = 1'b1; e.v1 = 1'b1;
    issue(TLBWI, 4'd7, e);
    step(); step();
    e.asid = 8'h33;
    issue(TLBP, 4'd0, e);
    step();
    chk("pg_miss", bus.res_miss, 0);
    chk("pg_index", bus.res_index, 7);
    step();

    // TLBR idx 3
    issue(TLBR, 4'd3, '0);
    chk("r_index", r_index, 3);
    chk("r_rv_exec", bus.res_valid, 0);
    step();
    chk("r_rv_resp", bus.res_valid, 1);
    chk("r_vpn2", bus.res_vpn2, 19'h12345);
    chk("r_asid", bus.res_asid, 8'h05);
    chk("r_pfn0", bus.res_pfn0, 20'hAB);
    chk("r_v0", bus.res_v0, 1);
    step();

    // Backpressure: hold res_ready low for 5 cycles, offer a write meanwhile
    bus.res_ready = 1'b0;
    issue(TLBR, 4'd7, '0);
    step();
    we_base = we_cnt;
    bus.op_code = TLBWI; bus.op_index = 4'd9; bus.op_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_rv", bus.res_valid, 1);
      chk("bp_vpn2", bus.res_vpn2, 19'h22222);
      chk("bp_pfn1", bus.res_pfn1, 20'h55);
      chk("bp_g", bus.res_g, 1);
      chk("bp_op_ready", bus.op_ready, 0);
      step();
    end
    bus.op_valid  = 1'b0;
    bus.res_ready = 1'b1;
    step();
    chk("bp_release", bus.op_ready, 1);
    chk("bp_no_write", we_cnt - we_base, 0);

    // TLBWR accepted while Random == 0
    for (int k = 0; k < TLBNUM && bus.random != 0; k++) step();
    e = '0; e.vpn2 = 19'h33333; e.asid = 8'hFF; e.pfn0 = 20'h777;
    issue(TLBWR, 4'd9, e);
    chk("wr_we", we, 1);
    chk("wr_w_index", w_index, 0);
    chk("wr_random_wrap", bus.random, 15);
    step(); step();
    issue(TLBP, 4'd0, e);
    step();
    chk("wr_probe_index", bus.res_index, 0);
    chk("wr_probe_miss", bus.res_miss, 0);
    step();

    // Cancel during EXEC of a TLBWI
    we_base = we_cnt;
    e = '0; e.vpn2 = 19'h44444;
    issue(TLBWI, 4'd5, e);
    bus.op_cancel = 1'b1;
    #1;
    chk("cx_we", we, 0);
    @(posedge clk); #1;
    bus.op_cancel = 1'b0;
    chk("cx_op_ready", bus.op_ready, 1);
    chk("cx_rv", bus.res_valid, 0);
    chk("cx_no_write", we_cnt - we_base, 0);

    // Cancel during RESP beats res_ready
    e = '0; e.vpn2 = 19'h12345; e.asid = 8'h05;
    issue(TLBP, 4'd0, e);
    step();
    bus.op_cancel = 1'b1;
    step();
    bus.op_cancel = 1'b0;
    chk("cr_op_ready", bus.op_ready, 1);
    chk("cr_rv", bus.res_valid, 0);

    // Async reset in RESP
    issue(TLBR, 4'd7, '0);
    step();
    chk("ar_rv_before", bus.res_valid, 1);
    #2 resetn = 1'b0;
    #1;
    chk("ar_rv_async", bus.res_valid, 0);
    chk("ar_op_ready", bus.op_ready, 1);
    @(posedge clk); #1;
    resetn = 1'b1;
    chk("ar_random", bus.random, 15);
    chk("ar_res_cleared", bus.res_pfn1, 0);

    // TLB contents survive the controller reset
    issue(TLBR, 4'd3, '0);
    step();
    chk("ar_r_vpn2", bus.res_vpn2, 19'h12345);
    chk("ar_r_pfn0", bus.res_pfn0, 20'hAB);
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
